// File: rtl/chunk_adder.sv
// chunk_adder: WIDTH-bit add over NCHUNK=WIDTH/CHUNK RUN cycles, result and done one cycle later; start ignored unless idle.
// Optional subtract mode (sub port, b inverted at capture) enabled by defining CHUNK_ADDER_SUB_EN.
module chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
`ifdef CHUNK_ADDER_SUB_EN
  ,
  input  logic             sub
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [WIDTH-1:0] b_in;
  logic [CHUNK-1:0] part;
  logic             rc, c_msb, c_out;

`ifdef CHUNK_ADDER_SUB_EN
  assign b_in = sub ? ~b : b;
`else
  assign b_in = b;
`endif

  // Bit-level ripple over the current chunk; c_msb is the carry into its top bit.
  always_comb begin
    rc    = carry_q;
    c_msb = carry_q;
    part  = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb = rc;
      part[i] = a_q[i] ^ b_q[i] ^ rc;
      rc      = (a_q[i] & b_q[i]) | (rc & (a_q[i] ^ b_q[i]));
    end
    c_out = rc;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_in;
          cnt_d   = '0;
          carry_d = cin;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[cnt_q*CHUNK +: CHUNK] = part;
        carry_d = c_out;
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        cnt_d   = cnt_q + 1'b1;
        // Results land on the edge into DONE so they are valid alongside done.
        if (cnt_q == LAST) begin
          sum_d   = acc_d;
          cout_d  = c_out;
          ovf_d   = c_msb ^ c_out;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunk_adder.sv
// Scoreboarded random/directed bench for chunk_adder (16/4 main instance, 8/8 secondary instance).
module tb_chunk_adder;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int NC = W / C;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start, cin, sub_i;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  logic         start8, cin8, sub8;
  logic [7:0]   a8, b8, sum8;
  logic         busy8, done8, cout8, ovf8;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  exp_t prev;

  always #5 clk = ~clk;

  chunk_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
`ifdef CHUNK_ADDER_SUB_EN
    , .sub(sub_i)
`endif
  );

  chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
`ifdef CHUNK_ADDER_SUB_EN
    , .sub(sub8)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: plain wide addition; ovf from the two's-complement sign rule.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tc, input logic ts);
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb        = ts ? ~tb : tb;
    full      = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, tc};
    model.sum  = full[W-1:0];
    model.cout = full[W];
    model.ovf  = (ta[W-1] == bb[W-1]) && (full[W-1] != ta[W-1]);
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (busy && done) chk("busy_and_done", 1, 0);
      if (done === 1'b1) begin
        if (sb_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sum", sum, e.sum);
          chk("cout", cout, e.cout);
          chk("ovf", ovf, e.ovf);
        end
      end
    end
  end

  // Caller is #1 past a rising edge with the DUT idle.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic ts);
    exp_t e;
    e = model(ta, tb, tc, ts);
    start = 1'b1; a = ta; b = tb; cin = tc; sub_i = ts;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < NC; i++) begin
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      chk("sum_hold", {sum, cout, ovf}, prev);
      // Scramble inputs and fire stray starts; none may affect the op in flight.
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub_i = 1'($urandom);
      start = (i == 1) ? 1'b1 : 1'($urandom);
      if (i == 1) begin a = 16'h1111; b = 16'h1111; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
    prev = e;
  endtask

  initial begin
    logic ts;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_i = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    prev = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", {sum, cout, ovf}, 0);
    rst = 1'b0;

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    do_op(16'h0000, 16'h0000, 1'b1, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0);
`ifdef CHUNK_ADDER_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    do_op(16'h0007, 16'h0005, 1'b1, 1'b1);
    do_op(16'h8000, 16'h0001, 1'b1, 1'b1);
`endif

    // Abort mid-RUN: reset in RUN cycle 3, no done may follow.
    start = 1'b1; a = 16'hABCD; b = 16'h1234; cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_out", {sum, cout, ovf}, 0);
    rst = 1'b0;
    prev = '0;
    for (int i = 0; i < NC + 3; i++) begin
      chk("abort_no_done", done, 0);
      @(posedge clk); #1;
    end
    do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
`ifdef CHUNK_ADDER_SUB_EN
      ts = 1'($urandom);
`else
      ts = 1'b0;
`endif
      do_op(W'($urandom), W'($urandom), 1'($urandom), ts);
    end

    // CHUNK == WIDTH: one RUN cycle, done in the next.
    for (int n = 0; n < 4; n++) begin
      logic [8:0] full8;
      if (n == 0) begin a8 = 8'hF0; b8 = 8'h20; cin8 = 1'b0; end
      else begin a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); end
      full8 = {1'b0, a8} + {1'b0, b8} + {8'd0, cin8};
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      a8 = 8'($urandom);
      chk("w8_busy", busy8, 1);
      chk("w8_done_run", done8, 0);
      @(posedge clk); #1;
      chk("w8_done", done8, 1);
      chk("w8_busy_done", busy8, 0);
      chk("w8_sum", sum8, full8[7:0]);
      chk("w8_cout", cout8, full8[8]);
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chunk_adder.md
# chunk_adder

Parametrised multi-cycle adder. It adds two WIDTH-bit operands plus a carry-in, processing CHUNK bits per clock through a small ripple adder and registering the carry between chunks. It trades latency for area and is the sequential, width-generic successor to the team's single-bit full adder. It sits behind a start/done handshake so a controller can issue one operation at a time.

## Interface
Parameters:
- WIDTH, 16, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock; 1 ≤ CHUNK ≤ WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- cin  in  1  carry-in; captured on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle completion pulse.
- sum  out  WIDTH  result register; holds the last completed result.
- cout  out  1  carry out of bit WIDTH-1 for the last result.
- ovf  out  1  signed overflow for the last result: carry into MSB XOR carry out of MSB.
- sub  in  1  only with CHUNK_ADDER_SUB_EN; captured on accepted start.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: capture a, b, cin (and sub) into shift registers. Set chunk counter to 0 and carry register to cin. Go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each cycle:
  - add the low CHUNK bits of the A and B shift registers plus the carry register;
  - write the CHUNK-bit result into the internal accumulator at chunk index = counter;
  - update the carry register and shift A/B right by CHUNK;
  - on the last chunk (counter = NCHUNK-1), record carry-into-MSB for ovf and go to DONE.
- DONE: copy the accumulator to sum, the final carry to cout, and the overflow flag to ovf. Assert done for exactly this cycle, then go to IDLE.
- Outputs sum, cout and ovf change only on entry to DONE. They are stable otherwise, including throughout RUN.
- start while in RUN or DONE is ignored, with no queuing. The operands in flight are unaffected by changes on a, b, cin.
- Arithmetic is modulo 2^WIDTH. cout is the unsigned carry. ovf uses the two's-complement interpretation.
- CHUNK = WIDTH is legal: RUN lasts one cycle.
- Counter width: clog2(NCHUNK), minimum 1 bit.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0; state IDLE; counter, carry and accumulator cleared.
- rst overrides everything, including an operation mid-RUN or a done pulse. The operation is abandoned and no done is produced.
- Start accepted at edge k: busy=1 during cycles k+1 … k+NCHUNK.
- done=1 and new sum/cout/ovf are valid in cycle k+NCHUNK+1, with busy=0 in that cycle.
- Earliest next start is accepted at edge k+NCHUNK+2, so throughput is one operation per NCHUNK+2 cycles.
- done and busy are never high in the same cycle.

## Configuration
- Macro: CHUNK_ADDER_SUB_EN.
- Defined:
  - sub port exists;
  - sub=1 at start captures ~b instead of b, so the result is a + ~b + cin (a - b with cin=1, a - b - 1 with cin=0);
  - cout=1 means no borrow;
  - ovf follows the same MSB-carry rule.
- Undefined: no sub port; the block always adds.

## Test plan
WIDTH=16, CHUNK=4 unless noted.
- After rst: all outputs 0. Start with a=0x1234, b=0x4321, cin=0 → busy for 4 cycles, then done pulse with sum=0x5555, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Also a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1. Also a=0x0000, b=0x0000, cin=1 → sum=0x0001.
- Start at RUN cycle 2 with a=0x1111, b=0x1111 → ignored. The first result completes unchanged, and exactly one done pulse occurs. Operands changed during RUN have no effect. sum holds its previous value until done.
- rst asserted in RUN cycle 3 → next cycle all outputs 0 and state IDLE, with no done. A new start then completes normally.
- With CHUNK_ADDER_SUB_EN: sub=1, a=0x0005, b=0x0007, cin=1 → sum=0xFFFE, cout=0. sub=1, a=0x0007, b=0x0005, cin=1 → sum=0x0002, cout=1.
- WIDTH=8, CHUNK=8: a=0xF0, b=0x20 → busy 1 cycle, done in the next cycle, sum=0x10, cout=1.
